// File: rtl/spi_segment_pkg.sv
// Shared definitions for the SPI segment receiver: command codes, frame geometry,
// readback sync byte and the receiver FSM state type.
package spi_segment_pkg;

  localparam logic [7:0] CMD_RAW   = 8'h01;
  localparam logic [7:0] CMD_HEX   = 8'h02;
  localparam logic [7:0] CMD_BLANK = 8'h03;

  // Leading byte returned on miso so the master can confirm framing.
  localparam logic [7:0] READBACK_SYNC = 8'hA5;

  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_e;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex digit to 7-segment decoder.
// Ports:
//   hex_i  4-bit nibble
//   seg_o  segment pattern, bit0=a ... bit6=g, active-high
module hex_to_seven_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    unique case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/spi_segment_receiver.sv
// SPI mode-0 slave receiving 16-bit {cmd, dat} frames and driving a registered
// 7-segment pattern. All SPI wires are oversampled on clk (f_clk >= 8 * f_sclk).
// Optional feature macro: SPI_READBACK_EN -- when defined, miso shifts out
// {8'hA5, previous seg_out} during each frame; otherwise miso is tied low.
// Parameters:
//   SYNC_STAGES   synchroniser depth on sclk/mosi/cs_n (minimum 2)
//   COMMON_ANODE  1 = segments stored and driven active-low
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   spi_sclk/spi_mosi/spi_cs_n  SPI inputs (asynchronous)
//   spi_miso      readback data
//   seg_out       segment pattern, bit0=a ... bit6=g, bit7=dp
//   frame_done    one-cycle pulse, frame accepted
//   frame_err     one-cycle pulse, frame rejected
module spi_segment_receiver
  import spi_segment_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [7:0] seg_out,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [7:0] SegReset = {8{COMMON_ANODE}};
  localparam logic [4:0] CntFull  = 5'(FRAME_BITS);
  localparam logic [4:0] CntSat   = 5'(FRAME_BITS + 1);

  // Synchronisers. cs_n resets high so reset release cannot fake a falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;

  // Receiver state
  state_e                  state_q, state_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [7:0]              seg_q, seg_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [7:0] cmd, dat;
  logic [6:0] hex_seg;
  logic [7:0] pattern;
  logic       cmd_legal;

  assign cmd = shift_q[15:8];
  assign dat = shift_q[7:0];

  hex_to_seven_seg u_hex (
    .hex_i (dat[3:0]),
    .seg_o (hex_seg)
  );

  always_comb begin
    pattern   = 8'h00;
    cmd_legal = 1'b1;
    case (cmd)
      CMD_RAW:   pattern = dat;
      CMD_HEX:   pattern = {dat[7], hex_seg};
      CMD_BLANK: pattern = 8'h00;
      default:   cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SHIFT: begin
        // A coincident sclk rise is absorbed before CHECK evaluates the count.
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt_q != CntSat) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (cs_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt_q == CntFull && cmd_legal) begin
          seg_d  = pattern ^ SegReset;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      seg_q     <= SegReset;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign seg_out    = seg_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

`ifdef SPI_READBACK_EN
  logic                  sclk_fall;
  logic [FRAME_BITS-1:0] tx_q, tx_d;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  always_comb begin
    tx_d = tx_q;
    if (state_q == IDLE && cs_fall) begin
      tx_d = {READBACK_SYNC, seg_q};
    end else if (state_q == SHIFT && sclk_fall) begin
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  // tx is loaded on the same edge that enters SHIFT, so miso is valid from then on.
  assign spi_miso = (state_q == SHIFT) & tx_q[FRAME_BITS-1];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_segment_receiver.sv
// Scoreboard bench: stimulus pushes expected {err, seg} per frame, monitors pop on
// frame_done/frame_err. A common-cathode and a common-anode instance share the SPI bus.
module tb_spi_segment_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso0, miso1;
  logic [7:0] seg0, seg1;
  logic       done0, err0, done1, err1;
  logic [31:0] rx_cap;

  always #5 clk = ~clk;

  spi_segment_receiver #(.SYNC_STAGES(2), .COMMON_ANODE(1'b0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .spi_cs_n   (cs_n),
    .spi_miso   (miso0),
    .seg_out    (seg0),
    .frame_done (done0),
    .frame_err  (err0)
  );

  spi_segment_receiver #(.SYNC_STAGES(2), .COMMON_ANODE(1'b1)) u_dut_ca (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .spi_cs_n   (cs_n),
    .spi_miso   (miso1),
    .seg_out    (seg1),
    .frame_done (done1),
    .frame_err  (err1)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] seg;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pattern given for the common-cathode part; the anode part stores the inverse.
  task automatic expect_frame(input logic err, input logic [7:0] seg);
    exp_t e0, e1;
    e0.err = err;
    e0.seg = seg;
    e1.err = err;
    e1.seg = ~seg;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && (done0 || err0)) begin
      if (q0.size() == 0) begin
        check("cc unexpected pulse", {30'd0, done0, err0}, 32'd0);
      end else begin
        e = q0.pop_front();
        check("cc status {done,err}", {30'd0, done0, err0}, {30'd0, ~e.err, e.err});
        check("cc seg_out", {24'd0, seg0}, {24'd0, e.seg});
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && (done1 || err1)) begin
      if (q1.size() == 0) begin
        check("ca unexpected pulse", {30'd0, done1, err1}, 32'd0);
      end else begin
        e = q1.pop_front();
        check("ca status {done,err}", {30'd0, done1, err1}, {30'd0, ~e.err, e.err});
        check("ca seg_out", {24'd0, seg1}, {24'd0, e.seg});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode 0: data set up half a period before the rising edge; miso captured at the rise.
  task automatic shift_bits(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = data[n-1-i];
      wait_clk(4);
      rx_cap = {rx_cap[30:0], miso0};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 40) begin
      wait_clk(1);
      k++;
    end
    check("pending expectations", q0.size() + q1.size(), 32'd0);
    q0.delete();
    q1.delete();
    wait_clk(8);
  endtask

  task automatic send_frame(input logic [31:0] data, input int n);
    rx_cap = '0;
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(data, n);
    wait_clk(4);
    cs_n = 1'b1;
    drain();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " seg_out cc"}, {24'd0, seg0}, 32'h00);
    check({tag, " seg_out ca"}, {24'd0, seg1}, 32'hFF);
    check({tag, " pulses"}, {28'd0, done0, err0, done1, err1}, 32'd0);
    check({tag, " miso"}, {30'd0, miso0, miso1}, 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    wait_clk(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_clk(6);
    check_reset_state("idle");

    expect_frame(1'b0, 8'hB6);
    send_frame(32'h01B6, 16);
    // Rejected frames must leave the pattern at B6.
    expect_frame(1'b1, 8'hB6);
    send_frame(32'h0A5C, 12);
    expect_frame(1'b1, 8'hB6);
    send_frame(32'h01B6F, 20);
    expect_frame(1'b1, 8'hB6);
    send_frame(32'h7E12, 16);

    expect_frame(1'b0, 8'hF7);
    send_frame(32'h028A, 16);
    expect_frame(1'b0, 8'h5E);
    send_frame(32'h020D, 16);
    expect_frame(1'b0, 8'h3F);
    send_frame(32'h0270, 16);
    expect_frame(1'b0, 8'h00);
    send_frame(32'h0355, 16);
    expect_frame(1'b0, 8'h5A);
    send_frame(32'h015A, 16);

    // Abort after the first 9 bits of 0x01,0xFF.
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(32'h003, 9);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid-frame reset");
    cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    check_reset_state("after reset release");

    expect_frame(1'b0, 8'h3C);
    send_frame(32'h013C, 16);

    expect_frame(1'b0, 8'h00);
    send_frame(32'h0100, 16);
`ifdef SPI_READBACK_EN
    check("miso readback", rx_cap, 32'h0000A53C);
`else
    check("miso tied low", rx_cap, 32'h0);
`endif

    check("final seg_out cc", {24'd0, seg0}, 32'h00);
    check("final seg_out ca", {24'd0, seg1}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
